// File: rtl/ssd_share_arbiter.sv
// Round-robin owner of the 4-digit seven segment display: one of four requesters shows its
// 16-bit hex value for DWELL cycles, with leading-zero blanking on the per-digit enable mask.
module ssd_share_arbiter #(
  parameter int DWELL    = 100_000_000,
  parameter int DW_W     = 27,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  input  logic        hold,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  mode
);

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  localparam logic [DW_W-1:0] CNT_LAST = DW_W'(DWELL - 1);

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [DW_W-1:0] cnt_q, cnt_d;
  logic [15:0]     disp_q, disp_d;
  logic [3:0]      mode_q, mode_d;

  logic [15:0] val_a [4];
  logic [2:0]  pick;
  logic        load;

  // Search order is last+1, last+2, last+3, last; bit 2 flags that a requester was found.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] lz_mask(input logic [15:0] v);
    logic [3:0] m;
    m[0] = 1'b1;
    m[1] = |v[15:4];
    m[2] = |v[15:8];
    m[3] = |v[15:12];
    return BLANK_LZ ? m : 4'b1111;
  endfunction

  assign val_a[0] = val0;
  assign val_a[1] = val1;
  assign val_a[2] = val2;
  assign val_a[3] = val3;
  assign pick     = rr_pick(req, ptr_q);

  always_comb begin
    // NOTE: every _d starts from its _q so that no path through the case leaves a variable
    // unassigned; skipping a default here is what turns combinational logic into a latch.
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    mode_d  = mode_q;
    load    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pick[2]) begin
          state_d = S_SHOW;
          owner_d = pick[1:0];
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      S_SHOW: begin
        load = 1'b1;
        if (!req[owner_q]) begin
          // Owner release wins over dwell expiry and ignores hold.
          cnt_d = '0;
          if (pick[2]) begin
            owner_d = pick[1:0];
          end else begin
            state_d = S_IDLE;
            load    = 1'b0;
          end
        end else if (!hold) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            owner_d = pick[1:0];
          end else begin
            cnt_d = cnt_q + DW_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      ptr_d   = owner_d;
      grant_d = 4'(1) << owner_d;
      busy_d  = 1'b1;
      disp_d  = val_a[owner_d];
      mode_d  = lz_mask(val_a[owner_d]);
    end else if (state_d == S_IDLE) begin
      grant_d = 4'b0000;
      busy_d  = 1'b0;
      mode_d  = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd3;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      disp_q  <= 16'h0000;
      mode_q  <= 4'b0000;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples the
      // values from before this edge, independent of statement order.
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      mode_q  <= mode_d;
    end
  end

  assign grant  = grant_q;
  assign owner  = owner_q;
  assign busy   = busy_q;
  assign digit0 = disp_q[3:0];
  assign digit1 = disp_q[7:4];
  assign digit2 = disp_q[11:8];
  assign digit3 = disp_q[15:12];
  assign mode   = mode_q;

endmodule

// File: tb/tb_ssd_share_arbiter.sv
// Scoreboard bench for ssd_share_arbiter with DWELL=4: stimulus queues hand-computed
// post-edge outputs, a negedge monitor pops and compares them.
module tb_ssd_share_arbiter;

  typedef struct packed {
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] disp;
    logic [3:0]  mode;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] val0 = 16'h0000, val1 = 16'h0000, val2 = 16'h0000, val3 = 16'h0000;
  logic        hold = 1'b0;
  logic [3:0]  grant, digit0, digit1, digit2, digit3, mode;
  logic [1:0]  owner;
  logic        busy;

  obs_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  ssd_share_arbiter #(.DWELL(4), .DW_W(3), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .hold(hold), .grant(grant), .owner(owner), .busy(busy),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.grant = grant;
    o.owner = owner;
    o.busy  = busy;
    o.disp  = {digit3, digit2, digit1, digit0};
    o.mode  = mode;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got grant=%b owner=%0d busy=%b digits=%h mode=%b, want grant=%b owner=%0d busy=%b digits=%h mode=%b",
               name, act.grant, act.owner, act.busy, act.disp, act.mode,
               exp.grant, exp.owner, exp.busy, exp.disp, exp.mode);
    end
  endtask

  // One rising edge per call with the currently driven inputs; queues the expected outputs.
  task automatic cyc(input string tag, input logic [3:0] g, input logic [1:0] o, input logic b,
                     input logic [15:0] d, input logic [3:0] m, input int n = 1);
    obs_t e;
    e = '{grant: g, owner: o, busy: b, disp: d, mode: m};
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sb_q.push_back(e);
      tag_q.push_back($sformatf("%s#%0d", tag, i));
    end
  endtask

  initial begin : monitor
    obs_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check(t, sample(), e);
      end
    end
  end

  initial begin : stimulus
    obs_t zero;
    zero = '0;

    cyc("in_reset", 4'b0000, 2'd0, 1'b0, 16'h0000, 4'b0000, 2);
    rst = 1'b1;
    cyc("idle_noreq", 4'b0000, 2'd0, 1'b0, 16'h0000, 4'b0000, 3);

    // Round-robin over requesters 0, 1 and 3.
    val0 = 16'h00A5; val1 = 16'h0020; val2 = 16'h1234; val3 = 16'hF000;
    req  = 4'b1011;
    cyc("rr_own0",  4'b0001, 2'd0, 1'b1, 16'h00A5, 4'b0011, 4);
    cyc("rr_own1",  4'b0010, 2'd1, 1'b1, 16'h0020, 4'b0011, 4);
    cyc("rr_own3",  4'b1000, 2'd3, 1'b1, 16'hF000, 4'b1111, 4);
    cyc("rr_wrap0", 4'b0001, 2'd0, 1'b1, 16'h00A5, 4'b0011, 4);
    cyc("rr_own1b", 4'b0010, 2'd1, 1'b1, 16'h0020, 4'b0011, 2);

    // Owner 1 drops at count 1: requester 3 takes over and gets a full dwell.
    req = 4'b1001;
    cyc("drop_to3",  4'b1000, 2'd3, 1'b1, 16'hF000, 4'b1111, 4);
    cyc("after_3to0", 4'b0001, 2'd0, 1'b1, 16'h00A5, 4'b0011, 1);

    // Hold freezes the dwell count at 1; rotation comes two cycles after release.
    req = 4'b0011;
    cyc("pre_hold", 4'b0001, 2'd0, 1'b1, 16'h00A5, 4'b0011, 1);
    hold = 1'b1;
    cyc("held",     4'b0001, 2'd0, 1'b1, 16'h00A5, 4'b0011, 10);
    hold = 1'b0;
    cyc("post_hold", 4'b0001, 2'd0, 1'b1, 16'h00A5, 4'b0011, 2);
    cyc("hold_rot", 4'b0010, 2'd1, 1'b1, 16'h0020, 4'b0011, 1);

    // Hold does not block an owner release.
    req = 4'b0001; hold = 1'b1;
    cyc("drop_in_hold", 4'b0001, 2'd0, 1'b1, 16'h00A5, 4'b0011, 1);
    hold = 1'b0;

    // Sole requester keeps the display across expiries; digits track the live value.
    cyc("sole_keep", 4'b0001, 2'd0, 1'b1, 16'h00A5, 4'b0011, 10);
    val0 = 16'h1000;
    cyc("live_1000", 4'b0001, 2'd0, 1'b1, 16'h1000, 4'b1111, 1);
    val0 = 16'h0000;
    cyc("live_0000", 4'b0001, 2'd0, 1'b1, 16'h0000, 4'b0001, 1);
    val0 = 16'h0300;
    cyc("live_0300", 4'b0001, 2'd0, 1'b1, 16'h0300, 4'b0111, 1);

    // Nobody requesting: idle with blank mask, digits and owner held.
    req = 4'b0000;
    cyc("to_idle", 4'b0000, 2'd0, 1'b0, 16'h0300, 4'b0000, 3);
    req = 4'b0100; hold = 1'b1;
    cyc("idle_hold_grant", 4'b0100, 2'd2, 1'b1, 16'h1234, 4'b1111, 3);
    hold = 1'b0;

    // Asynchronous reset while showing requester 2.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", sample(), zero);
    cyc("reset_held", 4'b0000, 2'd0, 1'b0, 16'h0000, 4'b0000, 2);
    rst = 1'b1;
    cyc("regrant_after_reset", 4'b0100, 2'd2, 1'b1, 16'h1234, 4'b1111, 1);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0)
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached, want stimulus to complete");
    $fatal(1, "timeout");
  end

endmodule
